// File: rtl/audio_echo_stage.sv
// Echo/delay stage between the codec ADC read side and DAC write side.
// Each stereo sample gets an attenuated, recirculating copy from a circular delay line added to it.
`timescale 1ns/1ps
module audio_echo_stage #(
  parameter int DATA_W      = 24,
  parameter int DEPTH_LOG2  = 12,
  parameter int ATTEN_SHIFT = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  input  logic              write_ready,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              clip
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACK     = 3'd1;
  localparam logic [2:0] S_CALC    = 3'd2;
  localparam logic [2:0] S_WAIT_WR = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MAX_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [2:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic                  primed_q, primed_d;
  logic [DATA_W-1:0]     inL_q, inR_q;
  logic [DATA_W-1:0]     outL_q, outR_q, outL_d, outR_d;
  logic                  read_q, write_q, clip_q, clip_d;
  logic [DATA_W-1:0]     ramL_q, ramR_q;

  logic [DATA_W-1:0] memL [2**DEPTH_LOG2];
  logic [DATA_W-1:0] memR [2**DEPTH_LOG2];

  logic signed [DATA_W-1:0] shL, shR;
  logic [DATA_W-1:0]        delL, delR, satL, satR, resL, resR;
  logic [DATA_W:0]          sumL, sumR;
  logic                     ovfL, ovfR;

  // Add the attenuated delayed sample one bit wider, then clamp on overflow.
  always_comb begin
    shL  = $signed(ramL_q) >>> ATTEN_SHIFT;
    shR  = $signed(ramR_q) >>> ATTEN_SHIFT;
    delL = primed_q ? shL : '0;
    delR = primed_q ? shR : '0;
    sumL = {inL_q[DATA_W-1], inL_q} + {delL[DATA_W-1], delL};
    sumR = {inR_q[DATA_W-1], inR_q} + {delR[DATA_W-1], delR};
    ovfL = sumL[DATA_W] ^ sumL[DATA_W-1];
    ovfR = sumR[DATA_W] ^ sumR[DATA_W-1];
    satL = ovfL ? (sumL[DATA_W] ? MAX_NEG : MAX_POS) : sumL[DATA_W-1:0];
    satR = ovfR ? (sumR[DATA_W] ? MAX_NEG : MAX_POS) : sumR[DATA_W-1:0];
    resL = enable ? satL : inL_q;
    resR = enable ? satR : inR_q;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    primed_d = primed_q;
    outL_d   = outL_q;
    outR_d   = outR_q;
    clip_d   = clip_q;
    case (state_q)
      S_IDLE:    if (read_ready) state_d = S_ACK;
      S_ACK:     state_d = S_CALC;
      S_CALC: begin
        outL_d  = resL;
        outR_d  = resR;
        clip_d  = clip_q | (enable & (ovfL | ovfR));
        state_d = S_WAIT_WR;
      end
      S_WAIT_WR: if (write_ready) state_d = S_WRITE;
      S_WRITE: begin
        ptr_d = ptr_q + DEPTH_LOG2'(1);
        if (ptr_q == {DEPTH_LOG2{1'b1}}) primed_d = 1'b1;
        state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      primed_q <= 1'b0;
      inL_q    <= '0;
      inR_q    <= '0;
      outL_q   <= '0;
      outR_q   <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      primed_q <= primed_d;
      outL_q   <= outL_d;
      outR_q   <= outR_d;
      clip_q   <= clip_d;
      read_q   <= (state_q == S_IDLE) && read_ready;
      write_q  <= (state_q == S_WAIT_WR) && write_ready;
      if (state_q == S_IDLE && read_ready) begin
        inL_q <= readdata_left;
        inR_q <= readdata_right;
      end
    end
  end

  // Delay line has no reset so it maps onto block RAM; primed_q hides stale contents.
  always_ff @(posedge CLOCK_50) begin
    if (state_q == S_CALC && !reset) begin
      memL[ptr_q] <= resL;
      memR[ptr_q] <= resR;
    end
    if (state_q == S_ACK) begin
      ramL_q <= memL[ptr_q];
      ramR_q <= memR[ptr_q];
    end
  end

  assign read            = read_q;
  assign write           = write_q;
  assign writedata_left  = outL_q;
  assign writedata_right = outR_q;
  assign clip            = clip_q;

endmodule

// File: tb/tb_audio_echo_stage.sv
// Randomised and directed bench for audio_echo_stage with a small delay line,
// checked against an arithmetic echo model held in integer arrays.
`timescale 1ns/1ps
module tb_audio_echo_stage;
  localparam int DW    = 24;
  localparam int DL2   = 2;
  localparam int AS    = 1;
  localparam int DEPTH = 1 << DL2;
  localparam int MAXV  = (1 << (DW-1)) - 1;
  localparam int MINV  = -(1 << (DW-1));

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, read_ready = 1'b0, write_ready = 1'b0;
  logic [DW-1:0] readdata_left = '0, readdata_right = '0;
  logic read, write, clip;
  logic [DW-1:0] writedata_left, writedata_right;

  int total = 0;
  int bad = 0;

  int mL[DEPTH];
  int mR[DEPTH];
  int mPtr;
  bit mPrimed;
  bit mClip;

  always #5 clk = ~clk;

  audio_echo_stage #(.DATA_W(DW), .DEPTH_LOG2(DL2), .ATTEN_SHIFT(AS)) dut (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .read_ready(read_ready),
    .readdata_left(readdata_left), .readdata_right(readdata_right),
    .write_ready(write_ready), .read(read), .write(write),
    .writedata_left(writedata_left), .writedata_right(writedata_right), .clip(clip)
  );

  // Model: output = clamp(in + delayed/2^AS) where delayed is what was stored DEPTH samples ago.
  task automatic modelReset();
    mPtr = 0;
    mPrimed = 0;
    mClip = 0;
  endtask

  task automatic modelStep(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit en,
                           output logic [DW-1:0] eL, output logic [DW-1:0] eR);
    int inV[2];
    int dV[2];
    int res[2];
    int s;
    inV[0] = $signed(l);
    inV[1] = $signed(r);
    dV[0] = mPrimed ? (mL[mPtr] >>> AS) : 0;
    dV[1] = mPrimed ? (mR[mPtr] >>> AS) : 0;
    for (int ch = 0; ch < 2; ch++) begin
      if (!en) res[ch] = inV[ch];
      else begin
        s = inV[ch] + dV[ch];
        if (s > MAXV) begin s = MAXV; mClip = 1; end
        else if (s < MINV) begin s = MINV; mClip = 1; end
        res[ch] = s;
      end
    end
    mL[mPtr] = res[0];
    mR[mPtr] = res[1];
    eL = res[0][DW-1:0];
    eR = res[1][DW-1:0];
    mPtr = (mPtr + 1) % DEPTH;
    if (mPtr == 0) mPrimed = 1;
  endtask

  task automatic doReset();
    reset = 1;
    read_ready = 0;
    write_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    modelReset();
  endtask

  // Drives one codec transaction; write_ready is withheld for wrHold cycles of WAIT_WR.
  task automatic runSample(input logic [DW-1:0] l, input logic [DW-1:0] r, input int wrHold,
                           input bit holdRR, output int readLat, output int writeLat,
                           output int readCnt, output int writeCnt, output int both,
                           output logic [DW-1:0] oL, output logic [DW-1:0] oR, output logic oClip);
    int n;
    n = 0; readLat = -1; writeLat = -1; readCnt = 0; writeCnt = 0; both = 0;
    oL = '0; oR = '0; oClip = 1'b0;
    readdata_left = l;
    readdata_right = r;
    read_ready = 1;
    write_ready = (wrHold == 0);
    while (writeLat < 0 && n < 300) begin
      @(posedge clk);
      #1 n++;
      if (read) begin
        readCnt++;
        if (readLat < 0) begin
          readLat = n;
          if (!holdRR) read_ready = 0;
        end
      end
      if (read && write) both++;
      if (write) begin
        writeCnt++;
        writeLat = n;
        oL = writedata_left;
        oR = writedata_right;
        oClip = clip;
      end
      if (n == 3 + wrHold) write_ready = 1;
    end
    if (writeLat >= 0) begin
      @(posedge clk);
      #1;
      if (write) writeCnt++;
      if (read) readCnt++;
      if (read && write) both++;
    end
    read_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (read !== 1'b0) begin bad++; $display("[TB] FAIL reset_read: got %b expected 0", read); end
    total++; if (write !== 1'b0) begin bad++; $display("[TB] FAIL reset_write: got %b expected 0", write); end
    total++; if (writedata_left !== '0) begin bad++; $display("[TB] FAIL reset_wdl: got %h expected 0", writedata_left); end
    total++; if (writedata_right !== '0) begin bad++; $display("[TB] FAIL reset_wdr: got %h expected 0", writedata_right); end
    total++; if (clip !== 1'b0) begin bad++; $display("[TB] FAIL reset_clip: got %b expected 0", clip); end
    reset = 0;
    modelReset();
  endtask

  task automatic test_bypass();
    int rl, wl, rc, wc, bo;
    logic [DW-1:0] oL, oR, eL, eR;
    logic oc;
    doReset();
    enable = 0;
    runSample(24'h123456, 24'hFEDCBA, 0, 0, rl, wl, rc, wc, bo, oL, oR, oc);
    modelStep(24'h123456, 24'hFEDCBA, 0, eL, eR);
    total++; if (rl != 1) begin bad++; $display("[TB] FAIL bypass_read_lat: got %0d expected 1", rl); end
    total++; if (wl != 4) begin bad++; $display("[TB] FAIL bypass_write_lat: got %0d expected 4", wl); end
    total++; if (rc != 1) begin bad++; $display("[TB] FAIL bypass_read_cnt: got %0d expected 1", rc); end
    total++; if (wc != 1) begin bad++; $display("[TB] FAIL bypass_write_cnt: got %0d expected 1", wc); end
    total++; if (bo != 0) begin bad++; $display("[TB] FAIL bypass_overlap: got %0d expected 0", bo); end
    total++; if (oL !== 24'h123456) begin bad++; $display("[TB] FAIL bypass_left: got %h expected 123456", oL); end
    total++; if (oR !== 24'hFEDCBA) begin bad++; $display("[TB] FAIL bypass_right: got %h expected fedcba", oR); end
    total++; if (oc !== 1'b0) begin bad++; $display("[TB] FAIL bypass_clip: got %b expected 0", oc); end
  endtask

  task automatic test_echo();
    int rl, wl, rc, wc, bo;
    logic [DW-1:0] oL, oR, eL, eR, inL;
    logic oc;
    logic [DW-1:0] expL [9] = '{24'h100000, 24'h0, 24'h0, 24'h0, 24'h080000,
                                24'h0, 24'h0, 24'h0, 24'h040000};
    doReset();
    enable = 1;
    for (int i = 0; i < DEPTH; i++) begin
      runSample('0, '0, 0, 0, rl, wl, rc, wc, bo, oL, oR, oc);
      modelStep('0, '0, 1, eL, eR);
    end
    for (int i = 0; i < 9; i++) begin
      inL = (i == 0) ? 24'h100000 : 24'h0;
      runSample(inL, '0, 0, 0, rl, wl, rc, wc, bo, oL, oR, oc);
      modelStep(inL, '0, 1, eL, eR);
      total++; if (oL !== expL[i]) begin bad++; $display("[TB] FAIL echo_left[%0d]: got %h expected %h", i, oL, expL[i]); end
      total++; if (oR !== '0) begin bad++; $display("[TB] FAIL echo_right[%0d]: got %h expected 0", i, oR); end
    end
  endtask

  task automatic test_saturation();
    int rl, wl, rc, wc, bo;
    logic [DW-1:0] oL, oR, eL, eR;
    logic oc;
    doReset();
    enable = 1;
    for (int i = 0; i < 6; i++) begin
      runSample(24'h7FFFFF, 24'h800000, 0, 0, rl, wl, rc, wc, bo, oL, oR, oc);
      modelStep(24'h7FFFFF, 24'h800000, 1, eL, eR);
      total++; if (oL !== 24'h7FFFFF) begin bad++; $display("[TB] FAIL sat_left[%0d]: got %h expected 7fffff", i, oL); end
      total++; if (oR !== 24'h800000) begin bad++; $display("[TB] FAIL sat_right[%0d]: got %h expected 800000", i, oR); end
      total++; if (oc !== (i >= DEPTH)) begin bad++; $display("[TB] FAIL sat_clip[%0d]: got %b expected %b", i, oc, (i >= DEPTH)); end
    end
  endtask

  task automatic test_pointer_wrap();
    int rl, wl, rc, wc, bo;
    logic [DW-1:0] oL, oR, eL, eR, inL, inR;
    logic oc;
    doReset();
    enable = 1;
    for (int i = 0; i < 9; i++) begin
      inL = DW'((i + 1) * 'h1000);
      inR = DW'(-(i + 1) * 'h0800);
      runSample(inL, inR, 0, 0, rl, wl, rc, wc, bo, oL, oR, oc);
      modelStep(inL, inR, 1, eL, eR);
      if (i < DEPTH) begin
        total++; if (oL !== inL) begin bad++; $display("[TB] FAIL wrap_unprimed[%0d]: got %h expected %h", i, oL, inL); end
      end else begin
        total++; if (oL !== eL || oR !== eR) begin bad++; $display("[TB] FAIL wrap_echo[%0d]: got %h/%h expected %h/%h", i, oL, oR, eL, eR); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int rl, wl, rc, wc, bo, n;
    logic [DW-1:0] oL, oR, eL, eR;
    logic oc;
    doReset();
    enable = 1;
    runSample(24'h012345, 24'h054321, 100, 1, rl, wl, rc, wc, bo, oL, oR, oc);
    modelStep(24'h012345, 24'h054321, 1, eL, eR);
    total++; if (rc != 1) begin bad++; $display("[TB] FAIL bp_read_cnt: got %0d expected 1", rc); end
    total++; if (wc != 1) begin bad++; $display("[TB] FAIL bp_write_cnt: got %0d expected 1", wc); end
    total++; if (wl != 104) begin bad++; $display("[TB] FAIL bp_write_lat: got %0d expected 104", wl); end
    total++; if (oL !== eL || oR !== eR) begin bad++; $display("[TB] FAIL bp_data: got %h/%h expected %h/%h", oL, oR, eL, eR); end
    read_ready = 1;
    @(posedge clk);
    #1;
    read_ready = 0;
    total++; if (read !== 1'b1) begin bad++; $display("[TB] FAIL bp_next_read: got %b expected 1", read); end
    modelStep(24'h012345, 24'h054321, 1, eL, eR);
    n = 0;
    write_ready = 1;
    while (!write && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    total++; if (n != 3) begin bad++; $display("[TB] FAIL bp_second_write_lat: got %0d expected 3", n); end
    total++; if (writedata_left !== eL) begin bad++; $display("[TB] FAIL bp_second_data: got %h expected %h", writedata_left, eL); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int rl, wl, rc, wc, bo;
    logic [DW-1:0] oL, oR, eL, eR, inL, inR;
    logic oc;
    doReset();
    enable = 1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      runSample(24'h7FFFFF, 24'h300000, 0, 0, rl, wl, rc, wc, bo, oL, oR, oc);
      modelStep(24'h7FFFFF, 24'h300000, 1, eL, eR);
    end
    total++; if (clip !== 1'b1) begin bad++; $display("[TB] FAIL rmid_clip_before: got %b expected 1", clip); end
    readdata_left = 24'h555555;
    readdata_right = 24'h2AAAAA;
    read_ready = 1;
    write_ready = 0;
    @(posedge clk);
    #1 read_ready = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1;
    total++; if (read !== 0 || write !== 0) begin bad++; $display("[TB] FAIL rmid_strobes: got %b%b expected 00", read, write); end
    total++; if (writedata_left !== '0 || writedata_right !== '0) begin bad++; $display("[TB] FAIL rmid_data: got %h/%h expected 0/0", writedata_left, writedata_right); end
    total++; if (clip !== 1'b0) begin bad++; $display("[TB] FAIL rmid_clip: got %b expected 0", clip); end
    reset = 0;
    modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      inL = DW'($urandom);
      inR = DW'($urandom);
      runSample(inL, inR, 0, 0, rl, wl, rc, wc, bo, oL, oR, oc);
      modelStep(inL, inR, 1, eL, eR);
      total++; if (oL !== inL || oR !== inR) begin bad++; $display("[TB] FAIL rmid_fresh[%0d]: got %h/%h expected %h/%h", i, oL, oR, inL, inR); end
    end
  endtask

  task automatic test_random();
    int rl, wl, rc, wc, bo, hold;
    logic [DW-1:0] oL, oR, eL, eR, inL, inR;
    logic oc;
    bit en;
    doReset();
    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(0, 3) != 0);
      enable = en;
      inL = DW'($urandom);
      inR = DW'($urandom) >>> $urandom_range(0, 4);
      hold = $urandom_range(0, 3);
      runSample(inL, inR, hold, 0, rl, wl, rc, wc, bo, oL, oR, oc);
      modelStep(inL, inR, en, eL, eR);
      total++; if (oL !== eL || oR !== eR) begin bad++; $display("[TB] FAIL rand_data[%0d]: got %h/%h expected %h/%h", i, oL, oR, eL, eR); end
      total++; if (oc !== mClip) begin bad++; $display("[TB] FAIL rand_clip[%0d]: got %b expected %b", i, oc, mClip); end
      total++; if (wl != 4 + hold || wc != 1 || bo != 0) begin bad++; $display("[TB] FAIL rand_handshake[%0d]: got lat=%0d wr=%0d ov=%0d expected lat=%0d wr=1 ov=0", i, wl, wc, bo, 4 + hold); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_echo();
    test_saturation();
    test_pointer_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
